hazard3_regfile_1wnr: RTL and testbench

// - Parametrised register file: one write port, N_RPORTS synchronous read ports, self-clearing after reset.
// - Successor to the fixed 1W2R file; sits between decode (read addresses) and writeback (write port).
// - Clears contents with a sequential init walk, not per-flop reset, so the array still infers as RAM.
// - MHARTID_VAL is preloaded into register 10 (a0).

---
 rtl/hazard3_regfile_1wnr.sv | 111 +++++++++++
 tb/tb_hazard3_regfile_1wnr.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard3_regfile_1wnr.sv
// rtl/hazard3_regfile_1wnr.sv - 1W/N-read register file with sequential clear walk (option macro HAZARD3_REGFILE_BYPASS_EN)
module hazard3_regfile_1wnr #(
    parameter int                N_REGS      = 16,
    parameter int                W_DATA      = 32,
    parameter int                W_ADDR      = 5,
    parameter int                N_RPORTS    = 2,
    parameter int                ZERO_X0     = 1,
    parameter logic [W_DATA-1:0] MHARTID_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_busy,
    input  logic [N_RPORTS-1:0]        ren,
    input  logic [N_RPORTS*W_ADDR-1:0] raddr,
    output logic [N_RPORTS*W_DATA-1:0] rdata,
    input  logic                       wen,
    input  logic [W_ADDR-1:0]          waddr,
    input  logic [W_DATA-1:0]          wdata
);

    // Array index only needs enough bits for N_REGS; upper address bits feed the range check.
    localparam int W_IDX = (N_REGS > 2) ? $clog2(N_REGS) : 1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [W_ADDR-1:0]          init_ctr_q, init_ctr_d;
    logic                       init_busy_q, init_busy_d;
    logic [N_RPORTS*W_DATA-1:0] rdata_q, rdata_d;

    // Storage deliberately has no reset so it can map onto RAM.
    logic [W_DATA-1:0] mem [N_REGS];

    logic              mem_we;
    logic [W_IDX-1:0]  mem_widx;
    logic [W_DATA-1:0] mem_wdata;
    logic              wr_accept;

    assign init_busy = init_busy_q;
    assign rdata     = rdata_q;

    // Next-state, the single RAM write port (shared by clear walk and writeback), and read muxing.
    always_comb begin
        state_d     = state_q;
        init_ctr_d  = init_ctr_q;
        init_busy_d = init_busy_q;
        rdata_d     = rdata_q;
        mem_we      = 1'b0;
        mem_widx    = init_ctr_q[W_IDX-1:0];
        mem_wdata   = '0;
        wr_accept   = 1'b0;
        if (!rst) begin
            if (state_q == S_INIT) begin
                mem_we     = 1'b1;
                mem_wdata  = (32'(init_ctr_q) == 32'd10) ? MHARTID_VAL : '0;
                init_ctr_d = init_ctr_q + W_ADDR'(1);
                rdata_d    = '0;
                if (32'(init_ctr_q) == 32'(N_REGS - 1)) begin
                    state_d     = S_RUN;
                    init_busy_d = 1'b0;
                end
            end else begin
                wr_accept = wen && (32'(waddr) < 32'(N_REGS))
                            && !((ZERO_X0 != 0) && (waddr == '0));
                mem_we    = wr_accept;
                mem_widx  = waddr[W_IDX-1:0];
                mem_wdata = wdata;
                for (int p = 0; p < N_RPORTS; p++) begin
                    if (ren[p]) begin
                        if ((32'(raddr[p*W_ADDR +: W_ADDR]) >= 32'(N_REGS))
                            || ((ZERO_X0 != 0) && (raddr[p*W_ADDR +: W_ADDR] == '0))) begin
                            rdata_d[p*W_DATA +: W_DATA] = '0;
`ifdef HAZARD3_REGFILE_BYPASS_EN
                        end else if (wr_accept && (raddr[p*W_ADDR +: W_ADDR] == waddr)) begin
                            rdata_d[p*W_DATA +: W_DATA] = wdata;
`endif
                        end else begin
                            rdata_d[p*W_DATA +: W_DATA] = mem[raddr[p*W_ADDR +: W_IDX]];
                        end
                    end
                end
            end
        end
    end

    // Control and read-data registers; reset restarts the clear walk from register 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_ctr_q  <= '0;
            init_busy_q <= 1'b1;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_ctr_q  <= init_ctr_d;
            init_busy_q <= init_busy_d;
            rdata_q     <= rdata_d;
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_hazard3_regfile_1wnr.sv
// tb/tb_hazard3_regfile_1wnr.sv - self-checking bench for hazard3_regfile_1wnr (ZERO_X0=1 and ZERO_X0=0 instances)
module tb_hazard3_regfile_1wnr;

`ifdef HAZARD3_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int NR = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ren;
    logic [9:0]  raddr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy_z, busy_n;
    logic [63:0] rdata_z, rdata_n;

    always #5 clk = ~clk;

    hazard3_regfile_1wnr #(.N_REGS(NR), .W_DATA(32), .W_ADDR(5), .N_RPORTS(2),
                           .ZERO_X0(1), .MHARTID_VAL(32'd3)) dut_z (
        .clk(clk), .rst(rst), .init_busy(busy_z), .ren(ren), .raddr(raddr),
        .rdata(rdata_z), .wen(wen), .waddr(waddr), .wdata(wdata));

    hazard3_regfile_1wnr #(.N_REGS(NR), .W_DATA(32), .W_ADDR(5), .N_RPORTS(2),
                           .ZERO_X0(0), .MHARTID_VAL(32'd3)) dut_n (
        .clk(clk), .rst(rst), .init_busy(busy_n), .ren(ren), .raddr(raddr),
        .rdata(rdata_n), .wen(wen), .waddr(waddr), .wdata(wdata));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: index 0 = ZERO_X0 instance, 1 = plain instance.
    logic [31:0] mm [2][32];
    logic [31:0] ex [2][2];
    int          busy_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] re, input logic [4:0] a0,
                        input logic [4:0] a1, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
        logic [4:0]  a;
        logic [31:0] v;
        bit          zero, acc;
        rst = r; ren = re; raddr = {a1, a0}; wen = we; waddr = wa; wdata = wd;
        @(posedge clk);
        if (r) begin
            busy_left = NR;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 32; k++) mm[i][k] = (k == 10) ? 32'd3 : 32'd0;
                ex[i][0] = 32'd0;
                ex[i][1] = 32'd0;
            end
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            for (int i = 0; i < 2; i++) begin
                zero = (i == 0);
                acc  = we && (wa < NR) && !(zero && wa == 0);
                for (int p = 0; p < 2; p++) begin
                    if (re[p]) begin
                        a = (p == 0) ? a0 : a1;
                        v = (a >= NR || (zero && a == 0)) ? 32'd0 : mm[i][a];
                        if (BYP && acc && wa == a) v = wd;
                        ex[i][p] = v;
                    end
                end
                if (acc) mm[i][wa] = wd;
            end
        end
        @(negedge clk);
        check("busy_z", {31'd0, busy_z}, {31'd0, busy_left > 0});
        check("busy_n", {31'd0, busy_n}, {31'd0, busy_left > 0});
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rdata_z_p%0d", p), rdata_z[p*32 +: 32], ex[0][p]);
            check($sformatf("rdata_n_p%0d", p), rdata_n[p*32 +: 32], ex[1][p]);
        end
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Counts cycles with init_busy high after rst drops, bounded.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_z) break;
            n++;
            idle();
        end
        check(name, n, NR);
    endtask

    typedef struct {
        logic [1:0]  ren;
        logic [4:0]  a0, a1;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t tbl [9];

    initial begin
        rst = 1'b1; ren = '0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;

        tbl[0] = '{2'b00, 5'd0,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 32'h0, 32'h0};
        tbl[1] = '{2'b11, 5'd5,  5'd5,  1'b0, 5'd0,  32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{2'b00, 5'd0,  5'd0,  1'b1, 5'd0,  32'h1234, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[3] = '{2'b11, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0, 32'h0, 32'h0};
        tbl[4] = '{2'b00, 5'd0,  5'd0,  1'b1, 5'd7,  32'h11, 32'h0, 32'h0};
        tbl[5] = '{2'b11, 5'd7,  5'd7,  1'b1, 5'd7,  32'hA5,
                   BYP ? 32'hA5 : 32'h11, BYP ? 32'hA5 : 32'h11};
        tbl[6] = '{2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'h0, 32'hA5, 32'hA5};
        tbl[7] = '{2'b11, 5'd20, 5'd10, 1'b0, 5'd0,  32'h0, 32'h0, 32'h3};
        tbl[8] = '{2'b11, 5'd20, 5'd20, 1'b1, 5'd20, 32'h99, 32'h0, 32'h0};

        // Reset state and init walk length
        do_reset();
        check("reset_busy", {31'd0, busy_z}, 32'd1);
        check("reset_rdata", rdata_z[31:0], 32'd0);
        count_busy("init_busy_cycles");

        // Post-init contents
        for (int r = 1; r < NR; r++) begin
            step(1'b0, 2'b11, 5'(r), 5'(r), 1'b0, 5'd0, 32'd0);
            check($sformatf("init_r%0d", r), rdata_z[31:0], (r == 10) ? 32'd3 : 32'd0);
        end

        // Directed table
        for (int t = 0; t < 9; t++) begin
            step(1'b0, tbl[t].ren, tbl[t].a0, tbl[t].a1, tbl[t].wen, tbl[t].wa, tbl[t].wd);
            check($sformatf("tbl%0d_p0", t), rdata_z[31:0],  tbl[t].e0);
            check($sformatf("tbl%0d_p1", t), rdata_z[63:32], tbl[t].e1);
            if (t == 3) check("x0_plain", rdata_n[31:0], 32'h1234);
        end

        // Port 1 holds while port 0 tracks rewrites of r2
        step(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd2, 32'h22);
        step(1'b0, 2'b11, 5'd2, 5'd2, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b01, 5'd2, 5'd2, 1'b1, 5'd2, 32'h100 + 32'(i));
            check("hold_p1", rdata_z[63:32], 32'h22);
        end
        step(1'b0, 2'b01, 5'd2, 5'd2, 1'b0, 5'd0, 32'd0);
        check("track_p0", rdata_z[31:0], 32'h102);

        // Reset in RUN, then again at init_ctr=6
        step(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 32'h55);
        step(1'b0, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
        check("r3_written", rdata_z[31:0], 32'h55);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 2'b11, 5'd3, 5'd3, 1'b1, 5'd3, 32'h77);
        do_reset();
        count_busy("reinit_busy_cycles");
        step(1'b0, 2'b11, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0);
        check("r3_cleared", rdata_z[31:0], 32'd0);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), 2'($urandom), 5'($urandom_range(0, 19)),
                 5'($urandom_range(0, 19)), 1'($urandom), 5'($urandom_range(0, 19)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
